// File: rtl/ctrl_sequencer_pkg.sv
// ctrl_sequencer_pkg: shared types and constants for the control sequencer.
//   op_t          - opcode encodings of the 9-bit accumulator core
//   ctrl_state_t  - run/halt FSM states
//   dec_t         - enable bundle produced by the opcode decoder
//   HALT_INSTR    - all-ones instruction, overrides MOV
//   DEF_TAP_ADDR  - default data-memory address that selects the tap path
package ctrl_sequencer_pkg;

    localparam int unsigned DEF_IW       = 9;
    localparam int unsigned DEF_TAP_ADDR = 62;
    localparam logic [DEF_IW-1:0] HALT_INSTR = 9'h1FF;

    typedef enum logic [2:0] {
        OP_LOAD   = 3'b000,
        OP_STORE  = 3'b001,
        OP_AND    = 3'b010,
        OP_XOR    = 3'b011,
        OP_ROL    = 3'b100,
        OP_BRANCH = 3'b101,
        OP_SET    = 3'b110,
        OP_MOV    = 3'b111
    } op_t;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        EXEC     = 3'd1,
        MEM_WAIT = 3'd2,
        WB       = 3'd3,
        HALT     = 3'd4
    } ctrl_state_t;

    typedef struct packed {
        logic reg_wr;
        logic mem_wr;
        logic mem_rd;
        logic imm;
        logic branch;
        logic pc_inc;
        logic is_load;
        logic is_halt;
    } dec_t;

endpackage

// File: rtl/ctrl_sequencer_if.sv
// ctrl_sequencer_if: bundle between the sequencer and its environment
// (instruction ROM, fetch unit, reg_file, data memory).
//   master : drives Start/Instruction/DatMemAddr/BranchFlag, observes controls
//   slave  : the sequencer itself
interface ctrl_sequencer_if
    import ctrl_sequencer_pkg::*;
#(
    parameter int unsigned IW  = DEF_IW,
    parameter int unsigned OPW = 3,
    parameter int unsigned TW  = IW - OPW,
    parameter int unsigned AW  = 8,
    parameter int unsigned CW  = 16
);
    logic           Start;
    logic [IW-1:0]  Instruction;
    logic [AW-1:0]  DatMemAddr;
    logic           BranchFlag;
    logic           PCInc;
    logic           Branch;
    logic [TW-1:0]  PCTarg;
    logic           RegWrEn;
    logic           MemWrEn;
    logic           MemRdEn;
    logic           LoadInst;
    logic           Immediate;
    logic           TapSel;
    logic [OPW-1:0] RegWriteIndex;
    logic           Busy;
    logic           Ack;
    logic [CW-1:0]  InstCount;

    modport master (
        output Start, Instruction, DatMemAddr, BranchFlag,
        input  PCInc, Branch, PCTarg, RegWrEn, MemWrEn, MemRdEn, LoadInst,
               Immediate, TapSel, RegWriteIndex, Busy, Ack, InstCount
    );

    modport slave (
        input  Start, Instruction, DatMemAddr, BranchFlag,
        output PCInc, Branch, PCTarg, RegWrEn, MemWrEn, MemRdEn, LoadInst,
               Immediate, TapSel, RegWriteIndex, Busy, Ack, InstCount
    );
endinterface

// File: rtl/ctrl_sequencer_decode.sv
// ctrl_decode: pure combinational opcode -> enable-bundle decode.
//   instr       : current instruction word
//   branch_flag : ALU condition, used only when CTRL_COND_BRANCH_EN is defined
//   dec         : enable bundle for the EXEC cycle
// Macro CTRL_COND_BRANCH_EN makes BRANCH conditional on branch_flag.
module ctrl_decode
    import ctrl_sequencer_pkg::*;
#(
    parameter int unsigned IW  = DEF_IW,
    parameter int unsigned OPW = 3
) (
    input  logic [IW-1:0] instr,
    input  logic          branch_flag,
    output dec_t          dec
);
    op_t op;
    assign op = op_t'(instr[IW-1 -: OPW]);

`ifndef CTRL_COND_BRANCH_EN
    logic unused_branch_flag;
    assign unused_branch_flag = branch_flag;
`endif

    // All-ones word is HALT and wins over the MOV decode.
    always_comb begin
        dec = '0;
        if (&instr) begin
            dec.is_halt = 1'b1;
        end else begin
            case (op)
                OP_LOAD:  begin dec.mem_rd = 1'b1; dec.is_load = 1'b1; end
                OP_STORE: begin dec.mem_wr = 1'b1; dec.pc_inc = 1'b1; end
                OP_SET:   begin dec.reg_wr = 1'b1; dec.imm = 1'b1; dec.pc_inc = 1'b1; end
                OP_BRANCH: begin
`ifdef CTRL_COND_BRANCH_EN
                    dec.branch = branch_flag;
                    dec.pc_inc = ~branch_flag;
`else
                    dec.branch = 1'b1;
`endif
                end
                default:  begin dec.reg_wr = 1'b1; dec.pc_inc = 1'b1; end
            endcase
        end
    end
endmodule

// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: multi-cycle control unit for the 9-bit accumulator core.
//   Clk, Reset : clock and synchronous active-high reset
//   bus        : slave side of ctrl_sequencer_if (Start/Instruction/
//                DatMemAddr/BranchFlag in; fetch, reg_file and memory
//                enables, Busy/Ack status and InstCount out)
// Run/halt FSM with a MEM_LAT-cycle load wait. Control outputs are
// combinational from state and Instruction; InstCount is registered.
// Macro CTRL_COND_BRANCH_EN (in ctrl_decode) makes BRANCH conditional.
module ctrl_sequencer
    import ctrl_sequencer_pkg::*;
#(
    parameter int unsigned IW       = DEF_IW,
    parameter int unsigned OPW      = 3,
    parameter int unsigned TW       = IW - OPW,
    parameter int unsigned AW       = 8,
    parameter int unsigned MEM_LAT  = 1,
    parameter int unsigned TAP_ADDR = DEF_TAP_ADDR,
    parameter int unsigned CW       = 16
) (
    input  logic          Clk,
    input  logic          Reset,
    ctrl_sequencer_if.slave bus
);
    localparam logic [AW-1:0] TAP        = AW'(TAP_ADDR);
    localparam logic [2:0]    WAIT_INIT  = (MEM_LAT == 0) ? 3'd0 : 3'(MEM_LAT - 1);

    ctrl_state_t   state;
    logic [2:0]    wait_cnt;
    logic [CW-1:0] inst_count;
    dec_t          dec;
    logic          retire;

    ctrl_decode #(.IW(IW), .OPW(OPW)) u_decode (
        .instr       (bus.Instruction),
        .branch_flag (bus.BranchFlag),
        .dec         (dec)
    );

    // A LOAD retires in WB; HALT never retires.
    assign retire = ((state == EXEC) && !dec.is_load && !dec.is_halt) || (state == WB);

    // State register, load-wait counter and retired-instruction counter.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= IDLE;
            wait_cnt   <= 3'd0;
            inst_count <= '0;
        end else begin
            if (retire) inst_count <= inst_count + CW'(1);
            case (state)
                IDLE, HALT: if (bus.Start) state <= EXEC;
                EXEC: begin
                    if (dec.is_halt) begin
                        state <= HALT;
                    end else if (dec.is_load) begin
                        state    <= (MEM_LAT == 0) ? WB : MEM_WAIT;
                        wait_cnt <= WAIT_INIT;
                    end
                end
                MEM_WAIT: begin
                    if (wait_cnt == 3'd0) state <= WB;
                    else                  wait_cnt <= wait_cnt - 3'd1;
                end
                WB:      state <= EXEC;
                default: state <= IDLE;
            endcase
        end
    end

    // Control outputs: only EXEC and WB drive enables.
    always_comb begin
        bus.PCInc     = 1'b0;
        bus.Branch    = 1'b0;
        bus.PCTarg    = '0;
        bus.RegWrEn   = 1'b0;
        bus.MemWrEn   = 1'b0;
        bus.MemRdEn   = 1'b0;
        bus.LoadInst  = 1'b0;
        bus.Immediate = 1'b0;
        bus.TapSel    = 1'b0;
        case (state)
            EXEC: begin
                bus.PCInc     = dec.pc_inc;
                bus.Branch    = dec.branch;
                bus.PCTarg    = dec.branch ? bus.Instruction[TW-1:0] : '0;
                bus.RegWrEn   = dec.reg_wr;
                bus.MemWrEn   = dec.mem_wr;
                bus.MemRdEn   = dec.mem_rd;
                bus.Immediate = dec.imm;
            end
            WB: begin
                bus.PCInc    = 1'b1;
                bus.RegWrEn  = 1'b1;
                bus.LoadInst = 1'b1;
                bus.TapSel   = (bus.DatMemAddr == TAP);
            end
            default: ;
        endcase
    end

    assign bus.RegWriteIndex = bus.Instruction[IW-1 -: OPW];
    assign bus.Busy          = (state == EXEC) || (state == MEM_WAIT) || (state == WB);
    assign bus.Ack           = (state == HALT);
    assign bus.InstCount     = inst_count;
endmodule

// File: tb/tb_ctrl_sequencer.sv
// tb_ctrl_sequencer: directed and random instruction streams for
// ctrl_sequencer (MEM_LAT=2, CW=4). Each instruction is expanded into the
// per-cycle control vectors it should produce; the retired count is
// tracked modulo 2^CW.
module tb_ctrl_sequencer;
    import ctrl_sequencer_pkg::*;

    localparam int unsigned MEM_LAT = 2;
    localparam int unsigned CW      = 4;
    localparam logic [8:0]  HALT_W  = 9'h1FF;

    typedef struct packed {
        logic       pc_inc;
        logic       branch;
        logic [5:0] targ;
        logic       reg_wr;
        logic       mem_wr;
        logic       mem_rd;
        logic       load;
        logic       imm;
        logic       tap;
        logic       busy;
        logic       ack;
    } outs_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ctrl_sequencer_if #(.CW(CW)) bus ();

    ctrl_sequencer #(.MEM_LAT(MEM_LAT), .CW(CW)) dut (
        .Clk   (clk),
        .Reset (reset),
        .bus   (bus)
    );

    int vectors     = 0;
    int miscompares = 0;
    logic [CW-1:0] exp_count;
    logic [8:0]    cur_ins;

    function automatic outs_t observed();
        outs_t o;
        o.pc_inc = bus.PCInc;    o.branch = bus.Branch;   o.targ = bus.PCTarg;
        o.reg_wr = bus.RegWrEn;  o.mem_wr = bus.MemWrEn;  o.mem_rd = bus.MemRdEn;
        o.load   = bus.LoadInst; o.imm    = bus.Immediate; o.tap  = bus.TapSel;
        o.busy   = bus.Busy;     o.ack    = bus.Ack;
        return o;
    endfunction

    function automatic outs_t quiet(input logic busy, input logic ack);
        outs_t o = '0;
        o.busy = busy;
        o.ack  = ack;
        return o;
    endfunction

    // What the first (EXEC) cycle of an instruction must show.
    function automatic outs_t exec_outs(input logic [8:0] ins, input logic flag);
        outs_t o = quiet(1'b1, 1'b0);
        logic taken;
`ifdef CTRL_COND_BRANCH_EN
        taken = flag;
`else
        taken = 1'b1 | flag;
`endif
        if (ins == HALT_W) return o;
        case (ins[8:6])
            3'd0: o.mem_rd = 1'b1;
            3'd1: begin o.mem_wr = 1'b1; o.pc_inc = 1'b1; end
            3'd5: begin
                if (taken) begin o.branch = 1'b1; o.targ = ins[5:0]; end
                else       o.pc_inc = 1'b1;
            end
            3'd6: begin o.reg_wr = 1'b1; o.imm = 1'b1; o.pc_inc = 1'b1; end
            default: begin o.reg_wr = 1'b1; o.pc_inc = 1'b1; end
        endcase
        return o;
    endfunction

    function automatic outs_t wb_outs(input logic [7:0] addr);
        outs_t o = quiet(1'b1, 1'b0);
        o.reg_wr = 1'b1;
        o.load   = 1'b1;
        o.pc_inc = 1'b1;
        o.tap    = (addr == 8'd62);
        return o;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_cycle(input string tag, input outs_t exp);
        outs_t obs;
        @(negedge clk);
        obs = observed();
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s outs: observed %h expected %h", tag, obs, exp);
        end
        vectors++;
        assert (bus.InstCount === exp_count) else begin
            miscompares++;
            $error("FAIL %s count: observed %0d expected %0d", tag, bus.InstCount, exp_count);
        end
        vectors++;
        assert (bus.RegWriteIndex === cur_ins[8:6]) else begin
            miscompares++;
            $error("FAIL %s regidx: observed %0d expected %0d", tag, bus.RegWriteIndex, cur_ins[8:6]);
        end
    endtask

    task automatic drive(input logic [8:0] ins, input logic flag, input logic [7:0] addr,
                         input logic start);
        cur_ins         = ins;
        bus.Instruction = ins;
        bus.BranchFlag  = flag;
        bus.DatMemAddr  = addr;
        bus.Start       = start;
    endtask

    // Run one instruction from EXEC to retirement (or into HALT).
    task automatic do_instr(input string tag, input logic [8:0] ins, input logic flag,
                            input logic [7:0] addr, input logic start_noise);
        drive(ins, flag, addr, start_noise);
        check_cycle(tag, exec_outs(ins, flag));
        tick();
        if (ins == HALT_W) return;
        if (ins[8:6] == 3'd0) begin
            for (int i = 0; i < int'(MEM_LAT); i++) begin
                bus.Start = 1'($urandom);
                check_cycle({tag, "_wait"}, quiet(1'b1, 1'b0));
                tick();
            end
            check_cycle({tag, "_wb"}, wb_outs(addr));
            tick();
        end
        exp_count = exp_count + CW'(1);
    endtask

    task automatic halt_hold(input int n);
        bus.Start = 1'b0;
        for (int i = 0; i < n; i++) begin
            check_cycle("halt", quiet(1'b0, 1'b1));
            tick();
        end
    endtask

    task automatic resume(input logic ack);
        bus.Start = 1'b1;
        check_cycle("start", quiet(1'b0, ack));
        tick();
        bus.Start = 1'b0;
    endtask

    initial begin
        logic [8:0] ins;
        logic [7:0] addr;

        reset     = 1'b1;
        exp_count = '0;
        drive(9'h000, 1'b0, 8'h00, 1'b0);
        tick();
        tick();
        reset = 1'b0;
        check_cycle("reset", quiet(1'b0, 1'b0));
        tick();

        // First AND straight out of IDLE.
        drive(9'b010_000_001, 1'b0, 8'h00, 1'b0);
        resume(1'b0);
        do_instr("and", 9'b010_000_001, 1'b0, 8'h00, 1'b0);

        // Load hitting the tap address, then one that misses it.
        do_instr("load_tap", 9'b000_000_000, 1'b0, 8'd62, 1'b0);
        do_instr("load_notap", 9'b000_011_000, 1'b1, 8'd61, 1'b1);

        do_instr("branch_f0", 9'b101_101010, 1'b0, 8'h00, 1'b0);
        do_instr("branch_f1", 9'b101_101010, 1'b1, 8'h00, 1'b0);
        do_instr("store", 9'b001_000_111, 1'b0, 8'h10, 1'b0);
        do_instr("set", 9'b110_010_101, 1'b0, 8'h00, 1'b0);
        do_instr("xor", 9'b011_111_000, 1'b0, 8'h00, 1'b1);
        do_instr("rol", 9'b100_001_001, 1'b0, 8'h00, 1'b0);
        do_instr("mov", 9'b111_111_110, 1'b0, 8'h00, 1'b0);

        // HALT holds Ack and the count until Start.
        do_instr("halt_exec", HALT_W, 1'b0, 8'h00, 1'b0);
        halt_hold(3);
        drive(9'b011_000_001, 1'b0, 8'h00, 1'b0);
        resume(1'b1);
        do_instr("after_halt", 9'b011_000_001, 1'b0, 8'h00, 1'b0);

        // Reset while waiting on a load.
        drive(9'b000_101_000, 1'b0, 8'd62, 1'b0);
        check_cycle("rst_issue", exec_outs(9'b000_101_000, 1'b0));
        tick();
        reset = 1'b1;
        check_cycle("rst_wait", quiet(1'b1, 1'b0));
        tick();
        reset     = 1'b0;
        exp_count = '0;
        resume(1'b0);
        do_instr("rst_resume", 9'b110_000_011, 1'b0, 8'h00, 1'b0);

        // Counter wrap: 17 SETs from zero.
        reset = 1'b1;
        tick();
        reset     = 1'b0;
        exp_count = '0;
        drive(9'b110_000_000, 1'b0, 8'h00, 1'b0);
        resume(1'b0);
        for (int i = 0; i < 17; i++) begin
            ins = {3'b110, 6'($urandom)};
            do_instr("wrap_set", ins, 1'b0, 8'h00, 1'b0);
        end
        do_instr("wrap_halt", HALT_W, 1'b0, 8'h00, 1'b0);
        halt_hold(1);
        resume(1'b1);

        // Random instruction stream.
        for (int n = 0; n < 300; n++) begin
            ins = 9'($urandom);
            if ($urandom_range(0, 15) == 0) ins = HALT_W;
            addr = ($urandom_range(0, 3) == 0) ? 8'd62 : 8'($urandom);
            do_instr("rand", ins, 1'($urandom), addr, ($urandom_range(0, 3) == 0));
            if (ins == HALT_W) begin
                halt_hold(int'($urandom_range(1, 3)));
                resume(1'b1);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
